// File: rtl/spi_xfer_arbiter_if.sv
// Bundle of requester, result and byte-engine signals around the
// SPI transfer arbiter.
interface spi_xfer_arbiter_if #(
  parameter int NREQ = 4,
  parameter int LW   = 4
);
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*8-1:0]  tx_data;
  logic [NREQ-1:0]    tx_take;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    cs_n;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_last;
  logic               err;
  logic               eng_start;
  logic [7:0]         eng_data;
  logic               eng_busy;
  logic               eng_done;
  logic [7:0]         eng_rx;

  modport slave (
    input  req, req_len, tx_data,
    input  eng_busy, eng_done, eng_rx,
    output tx_take, grant, cs_n,
    output rx_data, rx_valid, rx_last, err,
    output eng_start, eng_data
  );

  modport master (
    output req, req_len, tx_data,
    output eng_busy, eng_done, eng_rx,
    input  tx_take, grant, cs_n,
    input  rx_data, rx_valid, rx_last, err,
    input  eng_start, eng_data
  );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin sharing of one SPI byte engine among NREQ chip selects,
// with multi-byte bursts and a per-byte stall watchdog.
module spi_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int LW      = 4,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  spi_xfer_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);
  localparam logic [WW-1:0]   WMAX = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0]   GMAX = GW'(GAP - 1);
  localparam logic [IW-1:0]   IMAX = IW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LAUNCH, S_WAIT, S_GAP
  } state_e;

  state_e          st_q;
  logic [NREQ-1:0] grant_q, cs_n_q, take_q;
  logic [7:0]      rxd_q, engd_q;
  logic            rxv_q, rxl_q, err_q, start_q;
  logic [IW-1:0]   rr_q, idx_q;
  logic [LW-1:0]   len_q, cnt_q;
  logic [WW-1:0]   wd_q;
  logic [GW-1:0]   gap_q;

  logic [IW-1:0]   win;
  logic            hit;
  logic            last;
  logic            to_gap;

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    int j;
    j   = 0;
    win = '0;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(rr_q) + i) % NREQ;
      if (!hit && bus.req[j]) begin
        hit = 1'b1;
        win = IW'(j);
      end
    end
  end

  assign last = (cnt_q == len_q);

  // Done wins over an expiring watchdog on the same edge.
  always_comb begin
    to_gap = 1'b0;
    if (st_q == S_WAIT)
      to_gap = bus.eng_done ? last : (wd_q == WMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      grant_q <= '0;
      cs_n_q  <= '1;
      take_q  <= '0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
      rxl_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      engd_q  <= '0;
      rr_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      take_q  <= '0;
      rxv_q   <= 1'b0;
      rxl_q   <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          if (hit) begin
            idx_q   <= win;
            grant_q <= ONE << win;
            cs_n_q  <= ~(ONE << win);
            len_q   <= bus.req_len[win*LW +: LW];
            cnt_q   <= '0;
            wd_q    <= '0;
            st_q    <= S_SETUP;
          end
        end
        S_SETUP: st_q <= S_LAUNCH;
        S_LAUNCH: begin
          if (!bus.eng_busy) begin
            start_q <= 1'b1;
            engd_q  <= bus.tx_data[idx_q*8 +: 8];
            take_q  <= ONE << idx_q;
            wd_q    <= '0;
            st_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.eng_done) begin
            rxd_q <= bus.eng_rx;
            rxv_q <= 1'b1;
            rxl_q <= last;
            if (!last) begin
              cnt_q <= cnt_q + LW'(1);
              st_q  <= S_LAUNCH;
            end
          end else if (wd_q == WMAX) begin
            err_q <= 1'b1;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GMAX) st_q <= S_IDLE;
          else gap_q <= gap_q + GW'(1);
        end
        default: st_q <= S_IDLE;
      endcase
      if (to_gap) begin
        grant_q <= '0;
        cs_n_q  <= '1;
        rr_q    <= (idx_q == IMAX) ? '0 : idx_q + IW'(1);
        gap_q   <= '0;
        st_q    <= S_GAP;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.tx_take   = take_q;
  assign bus.rx_data   = rxd_q;
  assign bus.rx_valid  = rxv_q;
  assign bus.rx_last   = rxl_q;
  assign bus.err       = err_q;
  assign bus.eng_start = start_q;
  assign bus.eng_data  = engd_q;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Scoreboard bench for spi_xfer_arbiter: requester and engine models,
// grant-order and rx queues checked as the DUT produces output.
module tb_spi_xfer_arbiter;
  localparam int NREQ    = 4;
  localparam int LW      = 4;
  localparam int GAP     = 2;
  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } rx_t;

  logic clk = 1'b0;
  logic rst;

  spi_xfer_arbiter_if #(.NREQ(NREQ), .LW(LW)) bus ();

  spi_xfer_arbiter #(
    .NREQ(NREQ), .LW(LW), .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester model: byte list per requester, advanced on tx_take.
  logic [7:0]      mem [NREQ][16];
  int              ptr [NREQ];
  int              eptr[NREQ];
  int              takes[NREQ];
  bit [NREQ-1:0]   rq_clr = '0;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rq_clr[i]) ptr[i] = 0;
      if (bus.tx_take[i]) begin
        ptr[i]++;
        takes[i]++;
      end
      bus.tx_data[i*8 +: 8] = mem[i][ptr[i] & 15];
    end
  end

  // Engine model: echoes byte^FF after eng_dly cycles unless muted.
  int         eng_dly  = 3;
  bit         eng_mute = 1'b0;
  bit         pend     = 1'b0;
  int         cd       = 0;
  logic [7:0] echo;
  int         done_cyc = 0;

  always @(negedge clk) begin
    bus.eng_done = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (bus.eng_start && !eng_mute) begin
      pend = 1'b1;
      cd   = eng_dly;
      echo = bus.eng_data ^ 8'hFF;
    end else if (pend) begin
      cd--;
      if (cd == 0) begin
        bus.eng_done = 1'b1;
        bus.eng_rx   = echo;
        pend         = 1'b0;
        done_cyc     = cyc + 1;
      end
    end
  end

  // Monitor / scoreboard.
  logic [NREQ-1:0] gq[$];
  rx_t             rxq[$];
  rx_t             e_rx;
  logic [NREQ-1:0] g_prev = '0;
  int              g_cyc = 0, st_cyc = 0, err_cyc = 0, errs = 0;

  always @(negedge clk) begin
    if (rst) begin
      g_prev = '0;
    end else begin
      chk("cs_vs_grant", 32'(bus.cs_n ^ bus.grant), 32'({NREQ{1'b1}}));
      chk("cs_one_low", 32'($countones(~bus.cs_n) <= 1), 1);
      if (bus.grant != '0 && g_prev == '0) begin
        g_cyc = cyc;
        if (gq.size() == 0) chk("grant_extra", 32'(bus.grant), 0);
        else chk("grant_order", 32'(bus.grant), 32'(gq.pop_front()));
      end
      g_prev = bus.grant;
      if (bus.eng_start) st_cyc = cyc;
      if (bus.err) begin
        errs++;
        err_cyc = cyc;
      end
      if (bus.rx_valid) begin
        chk("rx_latency", cyc, done_cyc);
        if (rxq.size() == 0) begin
          chk("rx_extra", 32'(bus.rx_valid), 0);
        end else begin
          e_rx = rxq.pop_front();
          chk("rx_data", 32'(bus.rx_data), 32'(e_rx.d));
          chk("rx_last", 32'(bus.rx_last), 32'(e_rx.l));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_rx(input int r, input int n, input bit lst);
    rx_t e;
    for (int k = 0; k < n; k++) begin
      e.d = mem[r][(eptr[r] + k) & 15] ^ 8'hFF;
      e.l = lst && (k == n - 1);
      rxq.push_back(e);
    end
    eptr[r] += n;
  endtask

  task automatic wait_gq(input string tag, input int left, input int budget);
    int t = 0;
    while (gq.size() > left && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(t < budget), 1);
  endtask

  task automatic drain(input string tag, input int budget);
    int t = 0;
    while ((rxq.size() != 0 || gq.size() != 0 || bus.grant != '0)
           && t < budget) begin
      tick();
      t++;
    end
    chk(tag, 32'(t < budget), 1);
    tick(GAP + 2);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 0);
    chk({tag, "_cs_n"}, 32'(bus.cs_n), 32'({NREQ{1'b1}}));
    chk({tag, "_take"}, 32'(bus.tx_take), 0);
    chk({tag, "_rxd"}, 32'(bus.rx_data), 0);
    chk({tag, "_rxv"}, 32'(bus.rx_valid), 0);
    chk({tag, "_rxl"}, 32'(bus.rx_last), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
    chk({tag, "_start"}, 32'(bus.eng_start), 0);
    chk({tag, "_engd"}, 32'(bus.eng_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t, t0, e0;
    for (int i = 0; i < NREQ; i++)
      for (int k = 0; k < 16; k++)
        mem[i][k] = 8'($urandom);
    mem[2][0] = 8'hA1;
    mem[2][1] = 8'hB2;
    mem[2][2] = 8'hC3;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_len  = '0;
    bus.eng_busy = 1'b0;
    tick(2);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // Single 3-byte burst on requester 2, slow engine.
    eng_dly = 18;
    gq.push_back(4'b0100);
    rxq.push_back({8'h5E, 1'b0});
    rxq.push_back({8'h4D, 1'b0});
    rxq.push_back({8'h3C, 1'b1});
    eptr[2] += 3;
    t0 = takes[2];
    bus.req_len[2*LW +: LW] = LW'(2);
    bus.req = 4'b0100;
    wait_gq("single_grant_bound", 0, 20);
    bus.req = '0;
    chk("single_cs", 32'(bus.cs_n), 32'(4'b1011));
    tick(2);
    chk("single_start_lat", 32'(bus.eng_start), 1);
    chk("single_take0", 32'(bus.tx_take), 32'(4'b0100));
    t = 0;
    while (rxq.size() != 0 && t < 200) begin
      tick();
      t++;
      if (rxq.size() != 0)
        chk("single_cs_hold", 32'(bus.cs_n), 32'(4'b1011));
    end
    chk("single_rx_bound", 32'(t < 200), 1);
    for (int g = 0; g <= GAP; g++) begin
      chk("single_gap_cs", 32'(bus.cs_n), 32'(4'b1111));
      tick();
    end
    chk("single_takes", takes[2] - t0, 3);
    tick(2);

    // Round robin from pointer 0, all requesting single bytes.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    eng_dly = 3;
    bus.req_len = '0;
    gq.push_back(4'b0001);
    gq.push_back(4'b0010);
    gq.push_back(4'b0100);
    gq.push_back(4'b1000);
    gq.push_back(4'b0001);
    push_rx(0, 1, 1'b1);
    push_rx(1, 1, 1'b1);
    push_rx(2, 1, 1'b1);
    push_rx(3, 1, 1'b1);
    push_rx(0, 1, 1'b1);
    bus.req = 4'b1111;
    wait_gq("rr_grant_bound", 0, 400);
    bus.req = '0;
    drain("rr_drain_bound", 200);

    // Pointer now 1: requester 1 wins before requester 0.
    gq.push_back(4'b0010);
    gq.push_back(4'b0001);
    push_rx(1, 1, 1'b1);
    push_rx(0, 1, 1'b1);
    bus.req = 4'b0011;
    wait_gq("fair_grant_bound", 0, 100);
    bus.req = '0;
    drain("fair_drain_bound", 200);

    // Engine busy holds off the launch.
    bus.eng_busy = 1'b1;
    gq.push_back(4'b1000);
    push_rx(3, 1, 1'b1);
    bus.req = 4'b1000;
    wait_gq("busy_grant_bound", 0, 50);
    bus.req = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("busy_no_start", 32'(bus.eng_start), 0);
      chk("busy_no_take", 32'(bus.tx_take), 0);
    end
    bus.eng_busy = 1'b0;
    tick();
    chk("busy_start", 32'(bus.eng_start), 1);
    chk("busy_take", 32'(bus.tx_take), 32'(4'b1000));
    drain("busy_drain_bound", 200);

    // Watchdog abort on requester 1, then requester 2 served.
    eng_mute = 1'b1;
    e0 = errs;
    bus.req_len[1*LW +: LW] = LW'(1);
    bus.req_len[2*LW +: LW] = LW'(0);
    gq.push_back(4'b0010);
    gq.push_back(4'b0100);
    eptr[1] += 1;
    push_rx(2, 1, 1'b1);
    bus.req = 4'b0110;
    t = 0;
    while (errs == e0 && t < 300) begin
      tick();
      t++;
    end
    chk("to_err_bound", 32'(t < 300), 1);
    eng_mute = 1'b0;
    bus.req = 4'b0100;
    chk("to_err_lat", err_cyc - st_cyc, TIMEOUT);
    chk("to_cs_high", 32'(bus.cs_n), 32'(4'b1111));
    chk("to_grant_zero", 32'(bus.grant), 0);
    wait_gq("to_regrant_bound", 0, 50);
    bus.req = '0;
    chk("to_regrant_gap", g_cyc - err_cyc, GAP + 1);
    drain("to_drain_bound", 200);
    chk("to_err_count", errs - e0, 1);

    // Reset during byte 2 of a 4-byte burst; pointer back to 0.
    bus.req_len[3*LW +: LW] = LW'(3);
    bus.req_len[0*LW +: LW] = LW'(0);
    gq.push_back(4'b1000);
    push_rx(3, 1, 1'b0);
    t0 = takes[3];
    bus.req = 4'b1001;
    t = 0;
    while (takes[3] - t0 < 2 && t < 100) begin
      tick();
      t++;
    end
    chk("rstmid_take_bound", 32'(t < 100), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("rstmid");
    chk("rstmid_rxq", rxq.size(), 0);
    rq_clr = 4'b1000;
    eptr[3] = 0;
    tick(2);
    rq_clr = '0;
    gq.push_back(4'b0001);
    gq.push_back(4'b1000);
    push_rx(0, 1, 1'b1);
    push_rx(3, 4, 1'b1);
    rst = 1'b0;
    wait_gq("rstmid_g0_bound", 1, 50);
    bus.req[0] = 1'b0;
    wait_gq("rstmid_g3_bound", 0, 100);
    bus.req[3] = 1'b0;
    drain("rstmid_drain_bound", 300);
    chk("rstmid_takes", takes[3] - t0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
